// File: rtl/hline_zbuff_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : hline_zbuff_pkg                                          |
// | Description : Shared definitions for the hline_zbuff span engine:      |
// |               FSM state encoding, depth-function codes and a           |
// |               ceil-division helper used for chunk/beat counts.         |
// | Revision    : 2.0 - parametrised chunking, four depth functions        |
// +------------------------------------------------------------------------+
package hline_zbuff_pkg;

  // 4-bit state encoding; curr_state exposes these values directly.
  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_INIT       = 4'd1;
  localparam logic [3:0] S_LOOP_START = 4'd2;
  localparam logic [3:0] S_LOAD_Z     = 4'd3;
  localparam logic [3:0] S_LOAD_F     = 4'd4;
  localparam logic [3:0] S_INTERP     = 4'd5;
  localparam logic [3:0] S_WR_Z       = 4'd6;
  localparam logic [3:0] S_WR_F       = 4'd7;
  localparam logic [3:0] S_DONE       = 4'd8;
  localparam logic [3:0] S_DRAIN      = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE       = S_IDLE,
    ST_INIT       = S_INIT,
    ST_LOOP_START = S_LOOP_START,
    ST_LOAD_Z     = S_LOAD_Z,
    ST_LOAD_F     = S_LOAD_F,
    ST_INTERP     = S_INTERP,
    ST_WR_Z       = S_WR_Z,
    ST_WR_F       = S_WR_F,
    ST_DONE       = S_DONE,
    ST_DRAIN      = S_DRAIN
  } state_t;

  // Depth-function codes (new Z compared against stored Z, signed).
  localparam logic [1:0] ZF_LESS    = 2'b00;
  localparam logic [1:0] ZF_LEQ     = 2'b01;
  localparam logic [1:0] ZF_GREATER = 2'b10;
  localparam logic [1:0] ZF_ALWAYS  = 2'b11;

  // Number of chunks needed to cover len items in groups of burst.
  function automatic int chunk_count(input int len, input int burst);
    return (len + burst - 1) / burst;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hline_zstep.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hline_zstep                                              |
// | Description : Combinational per-pixel step: depth test of the running  |
// |               Z against the stored Z, and one Bresenham step of the    |
// |               Z accumulator / error term. Holds state when not live.   |
// | Ports       : zsum, error, slope, rem, z_in (Z_W), dx (LEN_W),         |
// |               zfunc (2), live (1) -> pass, zsum_next, error_next       |
// | Revision    : 2.0 - four depth functions, signed error compare         |
// +------------------------------------------------------------------------+
module hline_zstep
  import hline_zbuff_pkg::*;
#(
  parameter int Z_W   = 32,
  parameter int LEN_W = 16
) (
  input  logic [Z_W-1:0]   zsum,
  input  logic [Z_W-1:0]   error,
  input  logic [Z_W-1:0]   slope,
  input  logic [Z_W-1:0]   rem,
  input  logic [LEN_W-1:0] dx,
  input  logic [1:0]       zfunc,
  input  logic [Z_W-1:0]   z_in,
  input  logic             live,
  output logic             pass,
  output logic [Z_W-1:0]   zsum_next,
  output logic [Z_W-1:0]   error_next
);

  // Wide enough to hold signed error and unsigned dx without overflow.
  localparam int EW = ((Z_W > LEN_W) ? Z_W : LEN_W) + 1;

  logic [Z_W-1:0]        e_sum;
  logic signed [EW-1:0]  e_ext;
  logic signed [EW-1:0]  dx_ext;
  logic                  e_ge_dx;
  logic [Z_W-1:0]        slope_big;
  logic                  depth_ok;

  assign e_sum   = error + rem;
  assign e_ext   = {{(EW-Z_W){e_sum[Z_W-1]}}, e_sum};
  assign dx_ext  = {{(EW-LEN_W){1'b0}}, dx};
  assign e_ge_dx = (e_ext >= dx_ext);

  // Correction step moves one extra unit away from zero in slope's direction.
  assign slope_big = slope + (slope[Z_W-1] ? {Z_W{1'b1}} : Z_W'(1));

  always_comb begin
    depth_ok = 1'b0;
    case (zfunc)
      ZF_LESS:    depth_ok = ($signed(zsum) <  $signed(z_in));
      ZF_LEQ:     depth_ok = ($signed(zsum) <= $signed(z_in));
      ZF_GREATER: depth_ok = ($signed(zsum) >  $signed(z_in));
      default:    depth_ok = 1'b1;
    endcase
  end

  assign pass = live & depth_ok;

  always_comb begin
    zsum_next  = zsum;
    error_next = error;
    if (live) begin
      if (e_ge_dx) begin
        zsum_next  = zsum + slope_big;
        error_next = e_sum - dx_ext[Z_W-1:0];
      end else begin
        zsum_next  = zsum + slope;
        error_next = e_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hline_zbuff_fsm_v2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hline_zbuff_fsm_v2                                       |
// | Description : Depth-tested horizontal span engine. Per chunk: reads    |
// |               BURST_WORDS Z and frame words into the input FIFOs,      |
// |               interpolates Z, merges pixels into the output FIFOs and  |
// |               writes both buffers back.                                |
// | Ports       : clk, nreset; start, fb_addr, zbuff_addr, dx, slope, rem, |
// |               err, z1, rgbx, zfunc, z_fifo_in, f_fifo_in, axi_done in; |
// |               rd_req, wr_req, addr, FIFO steering strobes, z_out,      |
// |               f_out, done, busy, z_sum_out, pass_count, curr_state out |
// | Config      : HLINE_ZBUFF_SKIP_EN - skip write-back of chunks with no  |
// |               passing pixel, draining the output FIFOs instead.        |
// | Revision    : 2.0 - chunk/beat parameters, partial chunks, pass count  |
// +------------------------------------------------------------------------+
module hline_zbuff_fsm_v2
  import hline_zbuff_pkg::*;
#(
  parameter int BURST_WORDS = 256,
  parameter int BEAT_WORDS  = 4,
  parameter int ADDR_W      = 32,
  parameter int Z_W         = 32,
  parameter int LEN_W       = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [ADDR_W-1:0] fb_addr,
  input  logic [ADDR_W-1:0] zbuff_addr,
  input  logic [LEN_W-1:0]  dx,
  input  logic [Z_W-1:0]    slope,
  input  logic [Z_W-1:0]    rem,
  input  logic [Z_W-1:0]    err,
  input  logic [Z_W-1:0]    z1,
  input  logic [Z_W-1:0]    rgbx,
  input  logic [1:0]        zfunc,
  input  logic [Z_W-1:0]    z_fifo_in,
  input  logic [Z_W-1:0]    f_fifo_in,
  input  logic              axi_done,
  output logic              rd_req,
  output logic              wr_req,
  output logic [ADDR_W-1:0] addr,
  output logic              axi_bus_to_z_fifo,
  output logic              axi_bus_to_f_fifo,
  output logic              read_in_fifos,
  output logic              write_out_fifos,
  output logic              read_z_out_fifo,
  output logic              read_f_out_fifo,
  output logic [Z_W-1:0]    z_out,
  output logic [Z_W-1:0]    f_out,
  output logic              done,
  output logic              busy,
  output logic [Z_W-1:0]    z_sum_out,
  output logic [LEN_W-1:0]  pass_count,
  output logic [3:0]        curr_state
);

  localparam int                BEATS       = chunk_count(BURST_WORDS, BEAT_WORDS);
  localparam int                XW          = $clog2(BURST_WORDS) + 1;
  localparam int                BW          = $clog2(BEATS) + 1;
  localparam logic [XW-1:0]     BURST_X     = XW'(BURST_WORDS);
  localparam logic [BW-1:0]     LAST_BEAT   = BW'(BEATS - 1);
  localparam logic [31:0]       BURST_U     = 32'(BURST_WORDS);
  localparam logic [LEN_W-1:0]  BURST_LEN   = LEN_W'(BURST_WORDS);
  localparam logic [ADDR_W-1:0] BEAT_BYTES  = ADDR_W'(4 * BEAT_WORDS);
  localparam logic [ADDR_W-1:0] CHUNK_BYTES = ADDR_W'(4 * BURST_WORDS);

  state_t             state_q,      state_d;
  logic [LEN_W-1:0]   remaining_q,  remaining_d;
  logic [Z_W-1:0]     zsum_q,       zsum_d;
  logic [Z_W-1:0]     error_q,      error_d;
  logic [ADDR_W-1:0]  offset_q,     offset_d;
  logic [ADDR_W-1:0]  chunk_base_q, chunk_base_d;
  logic [LEN_W-1:0]   pass_count_q, pass_count_d;
  logic [XW-1:0]      xcnt_q,       xcnt_d;
  logic [LEN_W-1:0]   live_left_q,  live_left_d;
  logic [BW-1:0]      beat_q,       beat_d;
`ifdef HLINE_ZBUFF_SKIP_EN
  logic               chunk_pass_q, chunk_pass_d;
`endif

  logic               w_strobe;
  logic               w_live;
  logic               w_pass;
  logic [Z_W-1:0]     w_zsum_next;
  logic [Z_W-1:0]     w_error_next;

  // One FIFO word per INTERP cycle until xcnt runs out; the first
  // live_left words of the chunk are real pixels, the rest pass through.
  assign w_strobe = (state_q == ST_INTERP) && (xcnt_q != '0);
  assign w_live   = w_strobe && (live_left_q != '0);

  hline_zstep #(
    .Z_W   (Z_W),
    .LEN_W (LEN_W)
  ) u_zstep (
    .zsum       (zsum_q),
    .error      (error_q),
    .slope      (slope),
    .rem        (rem),
    .dx         (dx),
    .zfunc      (zfunc),
    .z_in       (z_fifo_in),
    .live       (w_live),
    .pass       (w_pass),
    .zsum_next  (w_zsum_next),
    .error_next (w_error_next)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    zsum_d       = zsum_q;
    error_d      = error_q;
    offset_d     = offset_q;
    chunk_base_d = chunk_base_q;
    pass_count_d = pass_count_q;
    xcnt_d       = xcnt_q;
    live_left_d  = live_left_q;
    beat_d       = beat_q;
`ifdef HLINE_ZBUFF_SKIP_EN
    chunk_pass_d = chunk_pass_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        remaining_d  = dx;
        zsum_d       = z1;
        error_d      = err;
        offset_d     = '0;
        pass_count_d = '0;
        state_d      = ST_LOOP_START;
      end
      ST_LOOP_START: begin
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else begin
          if (32'(remaining_q) > BURST_U) begin
            live_left_d = BURST_LEN;
            remaining_d = remaining_q - BURST_LEN;
          end else begin
            live_left_d = remaining_q;
            remaining_d = '0;
          end
          xcnt_d       = BURST_X;
          chunk_base_d = offset_q;
          beat_d       = '0;
`ifdef HLINE_ZBUFF_SKIP_EN
          chunk_pass_d = 1'b0;
`endif
          state_d      = ST_LOAD_Z;
        end
      end
      ST_LOAD_Z, ST_LOAD_F: begin
        if (axi_done) begin
          if (beat_q == LAST_BEAT) begin
            // Both buffers are read from the same chunk-relative offsets.
            beat_d   = '0;
            offset_d = chunk_base_q;
            state_d  = (state_q == ST_LOAD_Z) ? ST_LOAD_F : ST_INTERP;
          end else begin
            beat_d   = beat_q + BW'(1);
            offset_d = offset_q + BEAT_BYTES;
          end
        end
      end
      ST_INTERP: begin
        if (xcnt_q != '0) begin
          xcnt_d       = xcnt_q - XW'(1);
          zsum_d       = w_zsum_next;
          error_d      = w_error_next;
          pass_count_d = pass_count_q + LEN_W'(w_pass);
          if (w_live) live_left_d = live_left_q - LEN_W'(1);
`ifdef HLINE_ZBUFF_SKIP_EN
          chunk_pass_d = chunk_pass_q | w_pass;
`endif
        end else begin
          state_d = ST_WR_Z;
`ifdef HLINE_ZBUFF_SKIP_EN
          // Nothing changed in this chunk: discard the merged words.
          if (!chunk_pass_q) begin
            state_d = ST_DRAIN;
            xcnt_d  = BURST_X;
          end
`endif
        end
      end
      ST_WR_Z: begin
        if (axi_done) state_d = ST_WR_F;
      end
      ST_WR_F: begin
        if (axi_done) begin
          offset_d = chunk_base_q + CHUNK_BYTES;
          state_d  = ST_LOOP_START;
        end
      end
      ST_DRAIN: begin
        if (xcnt_q != '0) begin
          xcnt_d = xcnt_q - XW'(1);
        end else begin
          offset_d = chunk_base_q + CHUNK_BYTES;
          state_d  = ST_LOOP_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      zsum_q       <= '0;
      error_q      <= '0;
      offset_q     <= '0;
      chunk_base_q <= '0;
      pass_count_q <= '0;
      xcnt_q       <= '0;
      live_left_q  <= '0;
      beat_q       <= '0;
`ifdef HLINE_ZBUFF_SKIP_EN
      chunk_pass_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      zsum_q       <= zsum_d;
      error_q      <= error_d;
      offset_q     <= offset_d;
      chunk_base_q <= chunk_base_d;
      pass_count_q <= pass_count_d;
      xcnt_q       <= xcnt_d;
      live_left_q  <= live_left_d;
      beat_q       <= beat_d;
`ifdef HLINE_ZBUFF_SKIP_EN
      chunk_pass_q <= chunk_pass_d;
`endif
    end
  end

  // Requests drop in the completion cycle so the bus sees one pulse per beat.
  assign rd_req = ((state_q == ST_LOAD_Z) || (state_q == ST_LOAD_F)) && !axi_done;
  assign wr_req = ((state_q == ST_WR_Z)   || (state_q == ST_WR_F))   && !axi_done;

  always_comb begin
    case (state_q)
      ST_LOAD_F: addr = fb_addr    + offset_q;
      ST_WR_Z:   addr = zbuff_addr + chunk_base_q;
      ST_WR_F:   addr = fb_addr    + chunk_base_q;
      default:   addr = zbuff_addr + offset_q;
    endcase
  end

  assign axi_bus_to_z_fifo = (state_q == ST_LOAD_Z);
  assign axi_bus_to_f_fifo = (state_q == ST_LOAD_F);
  assign read_in_fifos     = w_strobe;
  assign write_out_fifos   = w_strobe;
  assign read_z_out_fifo   = (state_q == ST_WR_Z) || ((state_q == ST_DRAIN) && (xcnt_q != '0));
  assign read_f_out_fifo   = (state_q == ST_WR_F) || ((state_q == ST_DRAIN) && (xcnt_q != '0));

  assign z_out      = w_pass ? zsum_q : z_fifo_in;
  assign f_out      = w_pass ? rgbx   : f_fifo_in;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign z_sum_out  = zsum_q;
  assign pass_count = pass_count_q;
  assign curr_state = state_q;

endmodule
`default_nettype wire
